// File: rtl/bcd_display_scan_pkg.sv
// Shared constants for the 8-digit common-anode 7-segment scanner.
// All patterns are active-low, ordered seg[6:0] = g..a.
package bcd_display_scan_pkg;

  localparam int NUM_DIGITS = 8;

  localparam logic [6:0] SEG_0    = 7'h40;
  localparam logic [6:0] SEG_1    = 7'h79;
  localparam logic [6:0] SEG_2    = 7'h24;
  localparam logic [6:0] SEG_3    = 7'h30;
  localparam logic [6:0] SEG_4    = 7'h19;
  localparam logic [6:0] SEG_5    = 7'h12;
  localparam logic [6:0] SEG_6    = 7'h02;
  localparam logic [6:0] SEG_7    = 7'h78;
  localparam logic [6:0] SEG_8    = 7'h00;
  localparam logic [6:0] SEG_9    = 7'h10;
  localparam logic [6:0] SEG_DASH = 7'h3F;
  localparam logic [6:0] SEG_OFF  = 7'h7F;

  localparam logic [NUM_DIGITS-1:0] AN_OFF = 8'hFF;

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational nibble to active-low 7-segment pattern.
// Any non-BCD nibble (A..F) is shown as a dash.
module bcd_to_7seg
  import bcd_display_scan_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  // NOTE: a case with a default arm assigns seg on every path, so no latch is inferred.
  always_comb begin
    case (nibble)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_display_scan.sv
// Captures a packed-BCD word on the converter's idle rising edge and scans it
// onto an 8-digit multiplexed display with optional leading-zero blanking.
module bcd_display_scan
  import bcd_display_scan_pkg::*;
#(
  parameter int REFRESH_DIV   = 100000,
  parameter bit BLANK_LEADING = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        idle,
  input  logic [31:0] bcd,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int PW = (REFRESH_DIV < 2) ? 1 : $clog2(REFRESH_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(REFRESH_DIV - 1);

  if (REFRESH_DIV < 2) begin : g_cfg_error
    $error("bcd_display_scan: REFRESH_DIV must be >= 2");
  end

  logic [PW-1:0] pre;
  logic [2:0]    idx;
  logic [31:0]   shown;
  logic          have_data;
  logic          idle_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre       <= '0;
      idx       <= '0;
      shown     <= '0;
      have_data <= 1'b0;
      idle_q    <= 1'b0;
    end else begin
      idle_q <= idle;
      if (idle && !idle_q) begin
        shown     <= bcd;
        have_data <= 1'b1;
      end
      if (pre == PRE_LAST) begin
        pre <= '0;
        idx <= idx + 3'd1;
      end else begin
        pre <= pre + 1'b1;
      end
    end
  end

  // lead_zero[i] is set when nibbles i..7 of the captured word are all zero.
  logic [NUM_DIGITS-1:0] lead_zero;
  logic [3:0]            cur_nibble;
  logic [6:0]            cur_seg;
  logic                  dark;

  always_comb begin
    lead_zero = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      lead_zero[i] = ((shown >> (4 * i)) == 32'd0);
    end
    cur_nibble = shown[{idx, 2'b00} +: 4];
    dark       = !have_data || (BLANK_LEADING && (idx != 3'd0) && lead_zero[idx]);
  end

  bcd_to_7seg u_dec (
    .nibble (cur_nibble),
    .seg    (cur_seg)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an  <= AN_OFF;
      seg <= SEG_OFF;
    end else if (dark) begin
      an  <= AN_OFF;
      seg <= SEG_OFF;
    end else begin
      an  <= ~(8'b1 << idx);
      seg <= cur_seg;
    end
  end

  assign dp = 1'b1;

endmodule

// File: tb/tb_bcd_display_scan.sv
// Directed bench for bcd_display_scan with REFRESH_DIV=4; a second instance
// with leading-zero blanking disabled shares all inputs.
module tb_bcd_display_scan;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        idle;
  logic [31:0] bcd;
  logic [7:0]  an_a, an_b;
  logic [6:0]  seg_a, seg_b;
  logic        dp_a, dp_b;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  bcd_display_scan #(.REFRESH_DIV(4), .BLANK_LEADING(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .idle(idle), .bcd(bcd),
    .an(an_a), .seg(seg_a), .dp(dp_a)
  );

  bcd_display_scan #(.REFRESH_DIV(4), .BLANK_LEADING(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .idle(idle), .bcd(bcd),
    .an(an_b), .seg(seg_b), .dp(dp_b)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled at the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Sample 32 cycles (one full scan). Each lit digit must appear for exactly 4
  // cycles with its expected pattern; dark cycles must show all segments off.
  task automatic scan(input string tag, input bit use_b, input logic [7:0] lit,
                      input logic [55:0] segs);
    int cnt[8];
    int bad;
    logic [7:0] a;
    logic [6:0] s;
    bit found;
    bad = 0;
    for (int d = 0; d < 8; d++) cnt[d] = 0;
    for (int c = 0; c < 32; c++) begin
      step();
      a = use_b ? an_b : an_a;
      s = use_b ? seg_b : seg_a;
      if (a == 8'hFF) begin
        if (s != 7'h7F) bad++;
      end else begin
        found = 1'b0;
        for (int d = 0; d < 8; d++) begin
          if (a == ~(8'b1 << d)) begin
            found = 1'b1;
            cnt[d]++;
            if (s != segs[7*d +: 7]) bad++;
          end
        end
        if (!found) bad++;
      end
    end
    for (int d = 0; d < 8; d++)
      check($sformatf("%s_slot%0d_cycles", tag, d), cnt[d], lit[d] ? 4 : 0);
    check($sformatf("%s_bad_samples", tag), bad, 0);
  endtask

  task automatic new_value(input logic [31:0] value);
    idle = 1'b0;
    step();
    bcd  = value;
    idle = 1'b1;
    step();
    step();
  endtask

  initial begin
    int bad;
    bit found;
    rst_n = 1'b0;
    idle  = 1'b0;
    bcd   = 32'h0;
    repeat (3) @(negedge clk);

    check("rst_an_a",  an_a,  8'hFF);
    check("rst_seg_a", seg_a, 7'h7F);
    check("rst_dp_a",  dp_a,  1'b1);
    check("rst_an_b",  an_b,  8'hFF);
    check("rst_seg_b", seg_b, 7'h7F);
    check("rst_dp_b",  dp_b,  1'b1);

    // Test 1: no idle edge, display stays dark.
    rst_n = 1'b1;
    bad = 0;
    for (int c = 0; c < 64; c++) begin
      step();
      if (an_a != 8'hFF || seg_a != 7'h7F || an_b != 8'hFF || seg_b != 7'h7F) bad++;
    end
    check("t1_dark_cycles", bad, 0);

    // Test 2: 1234 with leading zeros blanked.
    new_value(32'h00001234);
    scan("t2", 1'b0, 8'h0F, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h79, 7'h24, 7'h30, 7'h19});

    // Test 3: zero shows only digit 0; unblanked instance shows all eight zeros.
    new_value(32'h00000000);
    scan("t3a", 1'b0, 8'h01, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40});
    scan("t3b", 1'b1, 8'hFF, {8{7'h40}});

    // Test 4: non-BCD nibbles as dashes, embedded zero lit.
    new_value(32'h0000A0B7);
    scan("t4", 1'b0, 8'h0F, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h3F, 7'h40, 7'h3F, 7'h78});

    // Test 5: idle held high ignores new bcd; a fresh edge captures it.
    bcd = 32'h99999999;
    step();
    step();
    scan("t5_hold", 1'b0, 8'h0F, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h3F, 7'h40, 7'h3F, 7'h78});
    idle = 1'b0;
    step();
    idle = 1'b1;
    step();
    step();
    check("t5_lit_after_edge", (an_a != 8'hFF), 1'b1);
    check("t5_seg_after_edge", seg_a, 7'h10);
    scan("t5_new", 1'b0, 8'hFF, {8{7'h10}});

    // Test 6: reset in the middle of slot 5.
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      step();
      if (an_a == 8'hDF) found = 1'b1;
    end
    check("t6_reach_slot5", found, 1'b1);
    rst_n = 1'b0;
    idle  = 1'b0;
    #1;
    check("t6_rst_an",  an_a,  8'hFF);
    check("t6_rst_seg", seg_a, 7'h7F);
    step();
    step();
    rst_n = 1'b1;
    bad = 0;
    for (int c = 0; c < 3; c++) begin
      step();
      if (an_a != 8'hFF || seg_a != 7'h7F) bad++;
    end
    check("t6_dark_after_release", bad, 0);
    // Capture edge lands on the first prescaler wrap, where the index moves to 1.
    idle = 1'b1;
    step();
    check("t6_capture_edge_an", an_a, 8'hFF);
    step();
    check("t6_first_lit_an",  an_a,  8'hFD);
    check("t6_first_lit_seg", seg_a, 7'h10);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
